// File: rtl/if_inst_queue_if.sv
// if_inst_queue_if: fetch-side and ID-side handshake bundle of the dual-issue instruction queue.
interface if_inst_queue_if #(parameter int DEPTH = 8, parameter int DW = 64);
  localparam int CW = $clog2(DEPTH) + 1;
  logic          line1_pre_valid_i;
  logic          line2_pre_valid_i;
  logic [DW-1:0] pre_line1_ibus;
  logic [DW-1:0] pre_line2_ibus;
  logic          now_allowin_o;
  logic          next_allowin_i;
  logic          line1_to_next_valid_o;
  logic          line2_to_next_valid_o;
  logic [DW-1:0] line1_to_next_obus;
  logic [DW-1:0] line2_to_next_obus;
  logic          excep_flush_i;
  logic          branch_flush_i;
  logic [CW-1:0] count_o;
  modport slave (
    input  line1_pre_valid_i, line2_pre_valid_i, pre_line1_ibus, pre_line2_ibus,
    input  next_allowin_i, excep_flush_i, branch_flush_i,
    output now_allowin_o, line1_to_next_valid_o, line2_to_next_valid_o,
    output line1_to_next_obus, line2_to_next_obus, count_o
  );
  modport master (
    output line1_pre_valid_i, line2_pre_valid_i, pre_line1_ibus, pre_line2_ibus,
    output next_allowin_i, excep_flush_i, branch_flush_i,
    input  now_allowin_o, line1_to_next_valid_o, line2_to_next_valid_o,
    input  line1_to_next_obus, line2_to_next_obus, count_o
  );
endinterface

// File: rtl/if_inst_queue.sv
// if_inst_queue: dual-issue circular FIFO between fetch and the IF->ID register, two in / two out per cycle.
module if_inst_queue #(
  parameter int DEPTH = 8,
  parameter int DW    = 64
) (
  input logic           clk,
  input logic           rst_n,
  if_inst_queue_if.slave q
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] head, tail;
  logic [CW-1:0] count;
  logic          flush, allow, push_en;
  logic [1:0]    push_n, pop_n;
  always_comb begin
    flush   = q.excep_flush_i | q.branch_flush_i;
    allow   = (CW'(DEPTH) - count) >= CW'(2);
    push_en = allow & ~flush;
    push_n  = push_en ? 2'(q.line1_pre_valid_i) + 2'(q.line2_pre_valid_i) : 2'd0;
    pop_n   = (q.next_allowin_i & ~flush) ? (count >= CW'(2) ? 2'd2 : 2'(count != '0)) : 2'd0;
  end
  // Slot 1 lands right after slot 0 when both are valid, otherwise directly at tail.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push_en && q.line1_pre_valid_i) mem[tail] <= q.pre_line1_ibus;
      if (push_en && q.line2_pre_valid_i) mem[q.line1_pre_valid_i ? tail + AW'(1) : tail] <= q.pre_line2_ibus;
      head  <= head + AW'(pop_n);
      tail  <= tail + AW'(push_n);
      count <= count + CW'(push_n) - CW'(pop_n);
    end
  end
  always_comb begin
    q.now_allowin_o         = allow;
    q.line1_to_next_valid_o = count >= CW'(1);
    q.line2_to_next_valid_o = count >= CW'(2);
    q.line1_to_next_obus    = mem[head];
    q.line2_to_next_obus    = mem[head + AW'(1)];
    q.count_o               = count;
  end
endmodule

// File: tb/tb_if_inst_queue.sv
// tb_if_inst_queue: randomized scenarios checked against a queue-based model of the instruction queue.
module tb_if_inst_queue;
  logic clk = 0;
  logic rst_n = 1;
  int   n_cmp = 0;
  int   n_err = 0;
  logic [63:0] mq[$];
  if_inst_queue_if #(.DEPTH(8), .DW(64)) bus();
  if_inst_queue #(.DEPTH(8), .DW(64)) dut (.clk(clk), .rst_n(rst_n), .q(bus.slave));
  always #5 clk = ~clk;

  function automatic logic [63:0] rd();
    return {$urandom, $urandom};
  endfunction

  task automatic idle_inputs();
    bus.line1_pre_valid_i = 0;
    bus.line2_pre_valid_i = 0;
    bus.pre_line1_ibus    = '0;
    bus.pre_line2_ibus    = '0;
    bus.next_allowin_i    = 0;
    bus.excep_flush_i     = 0;
    bus.branch_flush_i    = 0;
  endtask

  // Drives one cycle and advances the model: flush clears, else pop up to two, then push if two slots were free.
  task automatic cycle(input bit v1, input bit v2, input logic [63:0] d1, input logic [63:0] d2,
                       input bit nxt, input bit ef, input bit bf);
    int sz = mq.size();
    bus.line1_pre_valid_i = v1;
    bus.line2_pre_valid_i = v2;
    bus.pre_line1_ibus    = d1;
    bus.pre_line2_ibus    = d2;
    bus.next_allowin_i    = nxt;
    bus.excep_flush_i     = ef;
    bus.branch_flush_i    = bf;
    if (ef || bf) mq.delete();
    else begin
      for (int i = 0; i < (nxt ? (sz < 2 ? sz : 2) : 0); i++) void'(mq.pop_front());
      if (8 - sz >= 2 && v1) mq.push_back(d1);
      if (8 - sz >= 2 && v2) mq.push_back(d2);
    end
    @(posedge clk);
    #1;
    idle_inputs();
  endtask

  task automatic test_reset();
    logic [63:0] a = rd(), b = rd();
    idle_inputs();
    rst_n = 1;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 0;
    mq.delete();
    n_cmp++;
    if (bus.line1_to_next_valid_o !== 0 || bus.line2_to_next_valid_o !== 0 || bus.count_o !== 0 || bus.now_allowin_o !== 1) begin
      n_err++;
      $display("FAIL reset_state: v1=%b v2=%b cnt=%0d allow=%b, required 0 0 0 1", bus.line1_to_next_valid_o,
               bus.line2_to_next_valid_o, bus.count_o, bus.now_allowin_o);
    end
    n_cmp++;
    if (bus.line1_to_next_obus !== 64'h0 || bus.line2_to_next_obus !== 64'h0) begin
      n_err++;
      $display("FAIL reset_obus: %h %h, required 0 0", bus.line1_to_next_obus, bus.line2_to_next_obus);
    end
    cycle(1, 1, a, b, 0, 0, 0);
    n_cmp++;
    if (bus.line1_to_next_obus !== a || bus.line2_to_next_obus !== b || bus.count_o !== 2 ||
        bus.line1_to_next_valid_o !== 1 || bus.line2_to_next_valid_o !== 1) begin
      n_err++;
      $display("FAIL first_pair: l1=%h l2=%h cnt=%0d, required %h %h 2", bus.line1_to_next_obus,
               bus.line2_to_next_obus, bus.count_o, a, b);
    end
  endtask

  task automatic test_slot1_only();
    logic [63:0] c = rd();
    cycle(0, 0, 0, 0, 0, 1, 0);
    cycle(0, 1, rd(), c, 0, 0, 0);
    n_cmp++;
    if (bus.line1_to_next_obus !== c || bus.line1_to_next_valid_o !== 1 || bus.line2_to_next_valid_o !== 0 || bus.count_o !== 1) begin
      n_err++;
      $display("FAIL slot1_only: l1=%h v1=%b v2=%b cnt=%0d, required %h 1 0 1", bus.line1_to_next_obus,
               bus.line1_to_next_valid_o, bus.line2_to_next_valid_o, bus.count_o, c);
    end
    cycle(0, 0, 0, 0, 1, 0, 0);
    n_cmp++;
    if (bus.count_o !== 0 || bus.line1_to_next_valid_o !== 0) begin
      n_err++;
      $display("FAIL pop_single: cnt=%0d v1=%b, required 0 0", bus.count_o, bus.line1_to_next_valid_o);
    end
    cycle(0, 0, 0, 0, 1, 0, 0);
    n_cmp++;
    if (bus.count_o !== 0 || bus.now_allowin_o !== 1) begin
      n_err++;
      $display("FAIL pop_empty: cnt=%0d allow=%b, required 0 1", bus.count_o, bus.now_allowin_o);
    end
  endtask

  task automatic test_fill();
    int exp_cnt[6] = '{2, 4, 6, 8, 8, 8};
    for (int i = 0; i < 6; i++) begin
      cycle(1, 1, rd(), rd(), 0, 0, 0);
      n_cmp++;
      if (bus.count_o !== 4'(exp_cnt[i]) || bus.count_o !== 4'(mq.size())) begin
        n_err++;
        $display("FAIL fill_pairs[%0d]: cnt=%0d, required %0d", i, bus.count_o, exp_cnt[i]);
      end
    end
    n_cmp++;
    if (bus.now_allowin_o !== 0) begin
      n_err++;
      $display("FAIL full_allowin: %b, required 0", bus.now_allowin_o);
    end
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if (bus.line1_to_next_obus !== mq[0] || bus.line2_to_next_obus !== mq[1]) begin
        n_err++;
        $display("FAIL drain_order[%0d]: %h %h, required %h %h", i, bus.line1_to_next_obus,
                 bus.line2_to_next_obus, mq[0], mq[1]);
      end
      cycle(0, 0, 0, 0, 1, 0, 0);
    end
    cycle(0, 1, 0, rd(), 0, 0, 0);
    for (int i = 0; i < 5; i++) cycle(1, 1, rd(), rd(), 0, 0, 0);
    n_cmp++;
    if (bus.count_o !== 7 || bus.now_allowin_o !== 0) begin
      n_err++;
      $display("FAIL count7_boundary: cnt=%0d allow=%b, required 7 0", bus.count_o, bus.now_allowin_o);
    end
    while (mq.size() > 0) begin
      n_cmp++;
      if (bus.line1_to_next_obus !== mq[0] || bus.line1_to_next_valid_o !== 1) begin
        n_err++;
        $display("FAIL drain7: %h, required %h", bus.line1_to_next_obus, mq[0]);
      end
      cycle(0, 0, 0, 0, 1, 0, 0);
    end
  endtask

  task automatic test_back_to_back();
    cycle(1, 1, rd(), rd(), 0, 0, 0);
    cycle(1, 1, rd(), rd(), 0, 0, 0);
    for (int i = 0; i < 10; i++) begin
      cycle(1, 1, rd(), rd(), 1, 0, 0);
      n_cmp++;
      if (bus.count_o !== 4 || bus.now_allowin_o !== 1 || bus.line1_to_next_obus !== mq[0] || bus.line2_to_next_obus !== mq[1]) begin
        n_err++;
        $display("FAIL b2b[%0d]: cnt=%0d l1=%h l2=%h, required 4 %h %h", i, bus.count_o,
                 bus.line1_to_next_obus, bus.line2_to_next_obus, mq[0], mq[1]);
      end
    end
  endtask

  task automatic test_flush();
    logic [63:0] n1 = rd(), n2 = rd();
    cycle(0, 0, 0, 0, 0, 0, 1);
    cycle(1, 1, rd(), rd(), 0, 0, 0);
    cycle(1, 1, rd(), rd(), 0, 0, 0);
    cycle(1, 0, rd(), 0, 0, 0, 0);
    n_cmp++;
    if (bus.count_o !== 5) begin
      n_err++;
      $display("FAIL flush_setup: cnt=%0d, required 5", bus.count_o);
    end
    cycle(1, 1, rd(), rd(), 1, 0, 1);
    n_cmp++;
    if (bus.count_o !== 0 || bus.line1_to_next_valid_o !== 0 || bus.line2_to_next_valid_o !== 0) begin
      n_err++;
      $display("FAIL branch_flush: cnt=%0d v1=%b v2=%b, required 0 0 0", bus.count_o,
               bus.line1_to_next_valid_o, bus.line2_to_next_valid_o);
    end
    cycle(1, 1, n1, n2, 0, 0, 0);
    n_cmp++;
    if (bus.count_o !== 2 || bus.line1_to_next_obus !== n1 || bus.line2_to_next_obus !== n2) begin
      n_err++;
      $display("FAIL after_flush: cnt=%0d l1=%h l2=%h, required 2 %h %h", bus.count_o,
               bus.line1_to_next_obus, bus.line2_to_next_obus, n1, n2);
    end
    cycle(1, 1, rd(), rd(), 1, 1, 0);
    n_cmp++;
    if (bus.count_o !== 0) begin
      n_err++;
      $display("FAIL excep_flush: cnt=%0d, required 0", bus.count_o);
    end
  endtask

  task automatic test_async_reset();
    logic [63:0] a = rd(), b = rd();
    cycle(1, 1, rd(), rd(), 0, 0, 0);
    cycle(1, 0, rd(), 0, 0, 0, 0);
    #2;
    rst_n = 1;
    #1;
    mq.delete();
    n_cmp++;
    if (bus.line1_to_next_valid_o !== 0 || bus.line2_to_next_valid_o !== 0 || bus.count_o !== 0 || bus.now_allowin_o !== 1) begin
      n_err++;
      $display("FAIL async_reset: v1=%b v2=%b cnt=%0d allow=%b, required 0 0 0 1", bus.line1_to_next_valid_o,
               bus.line2_to_next_valid_o, bus.count_o, bus.now_allowin_o);
    end
    rst_n = 0;
    cycle(1, 1, a, b, 0, 0, 0);
    n_cmp++;
    if (bus.count_o !== 2 || bus.line1_to_next_obus !== a || bus.line2_to_next_obus !== b) begin
      n_err++;
      $display("FAIL post_reset_push: cnt=%0d l1=%h l2=%h, required 2 %h %h", bus.count_o,
               bus.line1_to_next_obus, bus.line2_to_next_obus, a, b);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      cycle(1'($urandom), 1'($urandom), rd(), rd(), $urandom_range(0, 2) != 0,
            $urandom_range(0, 40) == 0, $urandom_range(0, 40) == 0);
      n_cmp++;
      if (bus.count_o !== 4'(mq.size()) || bus.now_allowin_o !== (mq.size() <= 6) ||
          bus.line1_to_next_valid_o !== (mq.size() >= 1) || bus.line2_to_next_valid_o !== (mq.size() >= 2) ||
          (mq.size() >= 1 && bus.line1_to_next_obus !== mq[0]) || (mq.size() >= 2 && bus.line2_to_next_obus !== mq[1])) begin
        n_err++;
        $display("FAIL random[%0d]: cnt=%0d allow=%b v=%b%b l1=%h l2=%h, required cnt=%0d head=%h next=%h", i,
                 bus.count_o, bus.now_allowin_o, bus.line1_to_next_valid_o, bus.line2_to_next_valid_o,
                 bus.line1_to_next_obus, bus.line2_to_next_obus, mq.size(),
                 mq.size() >= 1 ? mq[0] : 64'h0, mq.size() >= 2 ? mq[1] : 64'h0);
      end
    end
  endtask

  initial begin
    test_reset();
    test_slot1_only();
    test_fill();
    test_back_to_back();
    test_flush();
    test_async_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
